// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: each channel is off, PWM-dimmed,
// blinking or breathing. One prescaler sets blink/breathe speed and one
// PWM counter is shared by all channels. Outputs are registered.
module led_pattern_gen #(
    parameter int NUM_CH = 3,
    parameter int PRE_W  = 24,
    parameter int PWM_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [PWM_W*NUM_CH-1:0] duty,
    output logic [NUM_CH-1:0]       led,
    output logic                    tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_PWM     = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_MAX  = {PRE_W{1'b1}};
    localparam logic [PWM_W-1:0] LVL_ZERO = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] LVL_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] LVL_MAX  = {PWM_W{1'b1}};

    // Shared timebase
    logic [PRE_W-1:0]  pre_cnt_r;
    logic [PWM_W-1:0]  pwm_cnt_r;

    // Per-channel state
    mode_e             mode_q_r    [NUM_CH];
    logic [NUM_CH-1:0] phase_r;
    logic [PWM_W-1:0]  level_r     [NUM_CH];
    dir_e              dir_r       [NUM_CH];

    // Per-channel decode and next-state values
    mode_e             mode_s      [NUM_CH];
    logic [PWM_W-1:0]  duty_s      [NUM_CH];
    logic [NUM_CH-1:0] mode_chg_s;
    logic [NUM_CH-1:0] phase_nxt_s;
    logic [PWM_W-1:0]  level_nxt_s [NUM_CH];
    dir_e              dir_nxt_s   [NUM_CH];
    logic [NUM_CH-1:0] led_nxt_s;

    // Per-channel next state: mode-entry initialisation takes priority over tick advance
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            mode_s[i]     = mode_e'(mode[2*i +: 2]);
            duty_s[i]     = duty[PWM_W*i +: PWM_W];
            mode_chg_s[i] = (mode_s[i] != mode_q_r[i]);

            // Blink phase
            if (mode_chg_s[i] && (mode_s[i] == MODE_BLINK)) begin
                phase_nxt_s[i] = 1'b0;
            end else if ((mode_q_r[i] == MODE_BLINK) && tick) begin
                phase_nxt_s[i] = ~phase_r[i];
            end else begin
                phase_nxt_s[i] = phase_r[i];
            end

            // Breathe triangle: endpoints are visited once, never repeated
            level_nxt_s[i] = level_r[i];
            dir_nxt_s[i]   = dir_r[i];
            if (mode_chg_s[i] && (mode_s[i] == MODE_BREATHE)) begin
                level_nxt_s[i] = LVL_ZERO;
                dir_nxt_s[i]   = DIR_UP;
            end else if ((mode_q_r[i] == MODE_BREATHE) && tick) begin
                case (dir_r[i])
                    DIR_UP: begin
                        if (level_r[i] == LVL_MAX) begin
                            dir_nxt_s[i]   = DIR_DOWN;
                            level_nxt_s[i] = LVL_MAX - LVL_ONE;
                        end else begin
                            level_nxt_s[i] = level_r[i] + LVL_ONE;
                        end
                    end
                    DIR_DOWN: begin
                        if (level_r[i] == LVL_ZERO) begin
                            dir_nxt_s[i]   = DIR_UP;
                            level_nxt_s[i] = LVL_ONE;
                        end else begin
                            level_nxt_s[i] = level_r[i] - LVL_ONE;
                        end
                    end
                    default: begin
                        level_nxt_s[i] = level_r[i];
                        dir_nxt_s[i]   = dir_r[i];
                    end
                endcase
            end else begin
                level_nxt_s[i] = level_r[i];
                dir_nxt_s[i]   = dir_r[i];
            end

            // LED drive from the live mode and the current counters/state
            case (mode_s[i])
                MODE_OFF:     led_nxt_s[i] = 1'b0;
                MODE_PWM:     led_nxt_s[i] = (pwm_cnt_r < duty_s[i]);
                MODE_BLINK:   led_nxt_s[i] = phase_r[i];
                MODE_BREATHE: led_nxt_s[i] = (pwm_cnt_r < level_r[i]);
                default:      led_nxt_s[i] = 1'b0;
            endcase
        end
    end

    // Timebase, per-channel state and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_r <= PRE_ZERO;
            pwm_cnt_r <= LVL_ZERO;
            tick      <= 1'b0;
            led       <= {NUM_CH{1'b0}};
            phase_r   <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q_r[i] <= MODE_OFF;
                level_r[i]  <= LVL_ZERO;
                dir_r[i]    <= DIR_UP;
            end
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
            tick      <= (pre_cnt_r == PRE_MAX);
            led       <= led_nxt_s;
            phase_r   <= phase_nxt_s;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q_r[i] <= mode_s[i];
                level_r[i]  <= level_nxt_s[i];
                dir_r[i]    <= dir_nxt_s[i];
            end
        end
    end

endmodule
